// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU. It produces one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at acceptance and skip the iteration phase.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             isRem_q, isRem_d;
    logic             negQ_q, negQ_d;
    logic             negR_q, negR_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             isSigned;
    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic             divByZero;
    logic             overflow;

    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remDiff;
    logic             qBit;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] finalQ;
    logic [WIDTH-1:0] finalR;

    assign isSigned    = ~op[0];
    assign dividendNeg = isSigned & dividend[WIDTH-1];
    assign divisorNeg  = isSigned & divisor[WIDTH-1];
    assign magA        = dividendNeg ? -dividend : dividend;
    assign magB        = divisorNeg  ? -divisor  : divisor;
    assign divByZero   = (divisor == '0);
    assign overflow    = isSigned && (dividend == MIN_VAL) && (divisor == '1);

    // quo_q starts as the dividend magnitude; quotient bits shift in from the LSB as dividend bits leave at the MSB.
    // The remainder always fits in WIDTH bits, so only the shifted trial value needs the extra bit.
    assign remShift = {rem_q, quo_q[WIDTH-1]};
    assign remDiff  = remShift - {1'b0, dvsr_q};
    assign qBit     = ~remDiff[WIDTH];
    assign remNext  = qBit ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign quoNext  = {quo_q[WIDTH-2:0], qBit};
    assign finalQ   = negQ_q ? -quoNext : quoNext;
    assign finalR   = negR_q ? -remNext : remNext;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        isRem_d  = isRem_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        result_d = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    cnt_d   = '0;
                    quo_d   = magA;
                    rem_d   = '0;
                    dvsr_d  = magB;
                    isRem_d = op[1];
                    negQ_d  = dividendNeg ^ divisorNeg;
                    negR_d  = dividendNeg;
                    if (divByZero) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = DONE;
                    end else if (overflow) begin
                        result_d = op[1] ? '0 : MIN_VAL;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    quo_d = quoNext;
                    rem_d = remNext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        result_d = isRem_q ? finalR : finalQ;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            isRem_q  <= 1'b0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            isRem_q  <= isRem_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. It combines directed corner cases with randomized operations.
// The expected results come from 64-bit integer arithmetic.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        kill = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] lastResult = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint na, nb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (o[0]) begin
            na = longint'(a);
            nb = longint'(b);
        end else begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end
        return o[1] ? 32'(na % nb) : 32'(na / nb);
    endfunction

    function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // One full operation: accept, scramble inputs, measure latency and busy time, then verify the single done pulse.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input bit pokeRun, input bit pokeDone, input string tag);
        int          cycles;
        int          busyCycles;
        int          expLat;
        logic [31:0] expRes;
        expRes = refModel(o, a, b);
        expLat = isSpecial(o, a, b) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
        cycles = 1;
        busyCycles = 0;
        while (!done && cycles < 40) begin
            if (busy) busyCycles++;
            if (pokeRun && cycles == 5) start = 1'b1;
            else if (pokeRun && cycles == 6) start = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (busy) busyCycles++;
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(expLat));
        checkOutput({tag, " result"}, result, expRes);
        if (pokeDone) begin
            start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom | 32'd1;
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " done cleared"}, 32'(done), 32'd0);
        checkOutput({tag, " idle after done"}, 32'(busy), 32'd0);
        checkOutput({tag, " result held"}, result, expRes);
        lastResult = expRes;
    endtask

    task automatic killRun(input int killCycle, input string tag);
        int cycles;
        int doneSeen;
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (cycles < killCycle) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " busy before kill"}, 32'(busy), 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput({tag, " busy after kill"}, 32'(busy), 32'd0);
        checkOutput({tag, " done after kill"}, 32'(done), 32'd0);
        checkOutput({tag, " result after kill"}, result, lastResult);
        doneSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput({tag, " no late done"}, 32'(doneSeen), 32'd0);
    endtask

    task automatic resetMidRun();
        int doneSeen;
        @(negedge clk);
        start = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lastResult = '0;
        checkOutput("reset mid-run busy", 32'(busy), 32'd0);
        checkOutput("reset mid-run done", 32'(done), 32'd0);
        checkOutput("reset mid-run result", result, 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("reset mid-run no done", 32'(doneSeen), 32'd0);
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        int          pick;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", result, 32'd0);

        applyStimulus(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, "DIVU 100/7");
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, "REMU 100/7");
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "DIV -7/2");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "REM -7/2");
        applyStimulus(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, "REM 7/-2");
        applyStimulus(2'b00, 32'd5, 32'd0, 1'b0, 1'b0, "DIV 5/0");
        applyStimulus(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, "REMU 5/0");
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "DIV overflow");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "REM overflow");
        applyStimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "DIVU big");
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, "DIVU start pokes");

        killRun(10, "kill cycle 10");
        applyStimulus(2'b01, 32'd9, 32'd3, 1'b0, 1'b0, "DIVU 9/3 after kill");
        killRun(32, "kill last cycle");
        resetMidRun();
        applyStimulus(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, "DIV after reset");

        for (int i = 0; i < 40; i++) begin
            rOp  = 2'($urandom);
            rA   = $urandom;
            pick = $urandom_range(0, 9);
            case (pick)
                0:       rB = 32'd0;
                1:       begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
                2, 3:    rB = 32'($urandom_range(1, 16));
                4:       rB = -32'($urandom_range(1, 16));
                default: rB = $urandom;
            endcase
            applyStimulus(rOp, rA, rB, 1'($urandom), 1'($urandom), $sformatf("random %0d op%0d", i, rOp));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
